// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - funct3 codes, FSM states and alignment helper for the load/store unit
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_RMW_READ  = 2'd2,
        ST_RMW_WRITE = 2'd3
    } lsu_state_e;

    // funct3[1:0] carries the access size for both loads and stores
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half lane extraction with extension, and store-lane merge
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_value_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word_i[{offset_i, 3'b000} +: 8];
        half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    load_value_o = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_value_o = {24'd0, byte_lane};
            F3_H:    load_value_o = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_value_o = {16'd0, half_lane};
            default: load_value_o = word_i;
        endcase

        store_word_o = word_i;
        case (funct3_i)
            F3_B: store_word_o[{offset_i, 3'b000} +: 8] = store_data_i[7:0];
            F3_H: begin
                if (offset_i[1]) store_word_o[31:16] = store_data_i[15:0];
                else             store_word_o[15:0]  = store_data_i[15:0];
            end
            default: store_word_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store to word-memory adapter with read-modify-write for SB/SH
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 8192
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_store_data,
    output logic        req_ready,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        access_fault,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_data_q, store_data_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] load_data_q, load_data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        load_valid_q, load_valid_d;
    logic        fault_q, fault_d;

    logic        accept;
    logic        illegal_f3;
    logic        out_of_range;
    logic        req_fault;
    logic        sw_now;
    logic [31:0] load_value;
    logic [31:0] store_word;

    assign req_ready    = (state_q == ST_IDLE) && !reset;
    assign accept       = req_valid && req_ready;
    assign illegal_f3   = req_write ? (req_funct3 > F3_W)
                                    : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    assign out_of_range = {2'b00, req_address[31:2]} >= 32'(MEM_SIZE);
    assign req_fault    = illegal_f3 || out_of_range || misaligned(req_funct3, req_address[1:0]);
    assign sw_now       = accept && req_write && !req_fault && (req_funct3 == F3_W);

    assign load_valid   = load_valid_q;
    assign load_data    = load_data_q;
    assign access_fault = fault_q;

    // Shared by LOAD_WAIT (extraction) and RMW_READ (merge); both see latched request fields
    lsu_lane_align u_lane_align (
        .word_i       (mem_read_data),
        .offset_i     (addr_q[1:0]),
        .funct3_i     (funct3_q),
        .store_data_i (store_data_q),
        .load_value_o (load_value),
        .store_word_o (store_word)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        store_data_d = store_data_q;
        merged_d     = merged_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        fault_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d       = req_address;
                    funct3_d     = req_funct3;
                    store_data_d = req_store_data;
                    if (req_fault)           fault_d = 1'b1;
                    else if (!req_write)     state_d = ST_LOAD_WAIT;
                    else if (!sw_now)        state_d = ST_RMW_READ;
                end
            end
            ST_LOAD_WAIT: begin
                load_data_d  = load_value;
                load_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_RMW_READ: begin
                merged_d = store_word;
                state_d  = ST_RMW_WRITE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory is addressed from the live request while idle so reads start in the accept cycle
    always_comb begin
        mem_write_enable = 1'b0;
        mem_address      = {addr_q[31:2], 2'b00};
        mem_write_data   = merged_q;
        case (state_q)
            ST_IDLE: begin
                mem_address      = {req_address[31:2], 2'b00};
                mem_write_data   = req_store_data;
                mem_write_enable = sw_now;
            end
            ST_RMW_WRITE: mem_write_enable = !reset;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            store_data_q <= '0;
            merged_q     <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            store_data_q <= store_data_d;
            merged_q     <= merged_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a word memory model
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_store_data;
    logic        req_ready;
    logic        load_valid;
    logic [31:0] load_data;
    logic        access_fault;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:8191];

    int checks = 0;
    int errors = 0;
    int fault_cnt = 0;
    int we_cnt = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        fault;
        logic [31:0] exp_load;
        logic [31:0] exp_word;
    } vec_t;
    vec_t vecs [$];

    load_store_unit #(.MEM_SIZE(8192)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_address      (req_address),
        .req_store_data   (req_store_data),
        .req_ready        (req_ready),
        .load_valid       (load_valid),
        .load_data        (load_data),
        .access_fault     (access_fault),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_write_enable) mem[mem_address[14:2]] <= mem_write_data;
        mem_read_data <= mem[mem_address[14:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Scoreboard: loads complete in issue order, so pop the oldest expectation
    always @(negedge clock) begin
        if (!reset) begin
            if (access_fault) fault_cnt++;
            if (mem_write_enable) we_cnt++;
            if (load_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load_valid: got load_data 0x%08h expected no load", load_data);
                end else begin
                    chk("scoreboard_load", load_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        req_valid      = 1'b1;
        req_write      = wr;
        req_funct3     = f3;
        req_address    = a;
        req_store_data = sd;
    endtask

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        int n = 0;
        step();
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got req_ready 0 expected 1 within 50 cycles");
        end
        drive(wr, f3, a, sd);
        step();
        req_valid = 1'b0;
    endtask

    function automatic void add(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic flt, input logic [31:0] el,
                                input logic [31:0] ew);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = a; v.sdata = sd;
        v.fault = flt; v.exp_load = el; v.exp_word = ew;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int w0;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_address = '0; req_store_data = '0;
        mem[0]    <= 32'h01234567;
        mem[1]    <= 32'h89ABCDEF;
        mem[4]    <= 32'hDEADBEEF;
        mem[8]    <= 32'h11223344;
        mem[8191] <= 32'h0BADF00D;

        add(0, F3_W,  32'h10,   32'h0,        0, 32'hDEADBEEF, 32'h0);
        add(1, F3_W,  32'h10,   32'h80FF1234, 0, 32'h0,        32'h80FF1234);
        add(0, F3_B,  32'h13,   32'h0,        0, 32'hFFFFFF80, 32'h0);
        add(0, F3_BU, 32'h13,   32'h0,        0, 32'h00000080, 32'h0);
        add(0, F3_H,  32'h12,   32'h0,        0, 32'hFFFF80FF, 32'h0);
        add(0, F3_HU, 32'h10,   32'h0,        0, 32'h00001234, 32'h0);
        add(0, F3_B,  32'h11,   32'h0,        0, 32'h00000012, 32'h0);
        add(0, F3_HU, 32'h12,   32'h0,        0, 32'h000080FF, 32'h0);
        add(1, F3_B,  32'h21,   32'h000000AB, 0, 32'h0,        32'h1122AB44);
        add(1, F3_H,  32'h22,   32'h0000BEEF, 0, 32'h0,        32'hBEEFAB44);
        add(1, F3_B,  32'h23,   32'hFFFFFF77, 0, 32'h0,        32'h77EFAB44);
        add(1, F3_H,  32'h20,   32'h12345678, 0, 32'h0,        32'h77EF5678);
        add(0, F3_W,  32'h20,   32'h0,        0, 32'h77EF5678, 32'h0);
        add(0, F3_H,  32'h03,   32'h0,        1, 32'h0,        32'h0);
        add(0, F3_W,  32'h22,   32'h0,        1, 32'h0,        32'h0);
        add(1, F3_W,  32'h21,   32'hFFFFFFFF, 1, 32'h0,        32'h77EF5678);
        add(1, F3_H,  32'h21,   32'hFFFFFFFF, 1, 32'h0,        32'h77EF5678);
        add(0, 3'b011, 32'h20,  32'h0,        1, 32'h0,        32'h0);
        add(0, 3'b110, 32'h20,  32'h0,        1, 32'h0,        32'h0);
        add(0, 3'b111, 32'h20,  32'h0,        1, 32'h0,        32'h0);
        add(1, 3'b100, 32'h20,  32'hFFFFFFFF, 1, 32'h0,        32'h77EF5678);
        add(1, F3_W,  32'h8000, 32'hAAAAAAAA, 1, 32'h0,        32'h01234567);
        add(0, F3_W,  32'h7FFC, 32'h0,        0, 32'h0BADF00D, 32'h0);
        add(0, F3_BU, 32'h8003, 32'h0,        1, 32'h0,        32'h0);
        add(0, F3_HU, 32'h11,   32'h0,        1, 32'h0,        32'h0);
        add(0, F3_B,  32'h00,   32'h0,        0, 32'h00000067, 32'h0);
        add(0, F3_B,  32'h07,   32'h0,        0, 32'hFFFFFF89, 32'h0);

        repeat (3) @(negedge clock);
        chk1("reset_req_ready", req_ready, 1'b0);
        chk1("reset_mem_we", mem_write_enable, 1'b0);
        chk1("reset_load_valid", load_valid, 1'b0);
        chk1("reset_access_fault", access_fault, 1'b0);
        chk("reset_load_data", load_data, 32'h0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk1("idle_req_ready", req_ready, 1'b1);

        foreach (vecs[i]) begin
            f0 = fault_cnt;
            w0 = we_cnt;
            if (!vecs[i].wr && !vecs[i].fault) exp_q.push_back(vecs[i].exp_load);
            issue(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sdata);
            repeat (4) @(negedge clock);
            chk($sformatf("v%0d_fault", i), 32'(fault_cnt - f0), {31'd0, vecs[i].fault});
            chk($sformatf("v%0d_writes", i), 32'(we_cnt - w0),
                {31'd0, vecs[i].wr && !vecs[i].fault});
            if (vecs[i].wr) chk($sformatf("v%0d_mem_word", i), mem[vecs[i].addr[14:2]], vecs[i].exp_word);
        end

        step();
        mem[4] <= 32'hDEADBEEF;
        mem[8] <= 32'h11223344;

        // LW latency: result pulse two cycles after the accept cycle
        exp_q.push_back(32'hDEADBEEF);
        step();
        drive(0, F3_W, 32'h10, 32'h0);
        @(negedge clock);
        chk("lw_mem_address", mem_address, 32'h10);
        chk1("lw_accept_we", mem_write_enable, 1'b0);
        step();
        req_valid = 1'b0;
        @(negedge clock);
        chk1("lw_t1_ready", req_ready, 1'b0);
        chk1("lw_t1_load_valid", load_valid, 1'b0);
        @(negedge clock);
        chk1("lw_t2_load_valid", load_valid, 1'b1);
        chk("lw_t2_load_data", load_data, 32'hDEADBEEF);
        chk1("lw_t2_ready", req_ready, 1'b1);

        // SB read-modify-write timing
        step();
        drive(1, F3_B, 32'h21, 32'h000000AB);
        @(negedge clock);
        chk1("sb_t0_we", mem_write_enable, 1'b0);
        step();
        req_valid = 1'b0;
        @(negedge clock);
        chk1("sb_t1_ready", req_ready, 1'b0);
        chk1("sb_t1_we", mem_write_enable, 1'b0);
        @(negedge clock);
        chk1("sb_t2_ready", req_ready, 1'b0);
        chk1("sb_t2_we", mem_write_enable, 1'b1);
        chk("sb_t2_address", mem_address, 32'h20);
        chk("sb_t2_wdata", mem_write_data, 32'h1122AB44);
        @(negedge clock);
        chk1("sb_t3_ready", req_ready, 1'b1);
        chk1("sb_t3_we", mem_write_enable, 1'b0);
        chk("sb_mem8", mem[8], 32'h1122AB44);

        // Misaligned LH: fault pulse, no write, load_data held
        step();
        drive(0, F3_H, 32'h03, 32'h0);
        @(negedge clock);
        chk1("lh_fault_t0_we", mem_write_enable, 1'b0);
        step();
        req_valid = 1'b0;
        @(negedge clock);
        chk1("lh_fault_t1_fault", access_fault, 1'b1);
        chk1("lh_fault_t1_ready", req_ready, 1'b1);
        chk1("lh_fault_t1_load_valid", load_valid, 1'b0);
        @(negedge clock);
        chk1("lh_fault_t2_fault", access_fault, 1'b0);
        chk("lh_fault_load_data_held", load_data, 32'hDEADBEEF);

        // SH interrupted by reset during RMW_READ
        step();
        drive(1, F3_H, 32'h22, 32'h0000BEEF);
        step();
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk1("sh_rst_we", mem_write_enable, 1'b0);
        chk1("sh_rst_ready", req_ready, 1'b0);
        step();
        reset = 1'b0;
        w0 = we_cnt;
        f0 = fault_cnt;
        @(negedge clock);
        chk1("sh_rst_idle_ready", req_ready, 1'b1);
        chk1("sh_rst_load_valid", load_valid, 1'b0);
        chk1("sh_rst_fault", access_fault, 1'b0);
        repeat (3) @(negedge clock);
        chk("sh_rst_no_writes", 32'(we_cnt - w0), 32'd0);
        chk("sh_rst_no_faults", 32'(fault_cnt - f0), 32'd0);
        chk("sh_rst_mem8", mem[8], 32'h1122AB44);

        // Back-to-back SW, one per cycle
        step();
        drive(1, F3_W, 32'h0, 32'hCAFEF00D);
        @(negedge clock);
        chk1("sw0_we", mem_write_enable, 1'b1);
        chk("sw0_address", mem_address, 32'h0);
        chk("sw0_wdata", mem_write_data, 32'hCAFEF00D);
        step();
        drive(1, F3_W, 32'h4, 32'h0BADCAFE);
        @(negedge clock);
        chk1("sw4_we", mem_write_enable, 1'b1);
        chk("sw4_address", mem_address, 32'h4);
        chk1("sw4_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        @(negedge clock);
        chk("sw0_mem", mem[0], 32'hCAFEF00D);
        chk("sw4_mem", mem[1], 32'h0BADCAFE);

        repeat (3) @(negedge clock);
        chk("scoreboard_pending", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
